// File: rtl/keycode_dispatch.sv
// rtl/keycode_dispatch.sv - HID report latch and per-player direction-key dispatch with auto-repeat
// Optional feature macro: KEY_REPEAT_EN (auto-repeat state and frame counter).
module keycode_dispatch #(
    parameter int NUM_SLOTS    = 6,
    parameter int REPEAT_DELAY = 8,
    parameter int REPEAT_RATE  = 4
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   key_valid,
    input  logic [8*NUM_SLOTS-1:0] keycodes,
    input  logic                   frame_tick,
    output logic [7:0]             keycode_p1,
    output logic [7:0]             keycode_p2,
    output logic                   emit_p1,
    output logic                   emit_p2
);

    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
        $error("keycode_dispatch: REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end

`ifdef KEY_REPEAT_EN
    localparam int MAX_CNT = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
`else
    typedef enum logic {IDLE, HOLD} state_t;
`endif

    function automatic logic legal(input int player, input logic [7:0] c);
        if (player == 0)
            return c inside {8'h04, 8'h07, 8'h16, 8'h1A};
        return c inside {8'h4F, 8'h50, 8'h51, 8'h52};
    endfunction

    logic [8*NUM_SLOTS-1:0] latch_q;
    logic                   rollover;

    always_comb begin
        rollover = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++)
            if (keycodes[8*i +: 8] == 8'h01)
                rollover = 1'b1;
    end

    // ErrorRollOver reports carry no usable key state, so the previous report stays in force
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            latch_q <= '0;
        else if (key_valid && !rollover)
            latch_q <= keycodes;
    end

    logic [7:0] code_w [2];
    logic       emit_w [2];

    for (genvar p = 0; p < 2; p++) begin : g_player
        logic [7:0] sel, cur_q, cur_d, code_q, code_d;
        logic       emit_q, emit_d;
        state_t     state_q, state_d;
`ifdef KEY_REPEAT_EN
        logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

        // Scan downward so the lowest-index legal slot is the last assignment and wins
        always_comb begin
            sel = 8'h00;
            for (int i = NUM_SLOTS - 1; i >= 0; i--)
                if (legal(p, latch_q[8*i +: 8]))
                    sel = latch_q[8*i +: 8];
        end

        always_comb begin
            state_d = state_q;
            cur_d   = cur_q;
            code_d  = code_q;
            emit_d  = 1'b0;
`ifdef KEY_REPEAT_EN
            cnt_d   = cnt_q;
`endif
            if (frame_tick) begin
                code_d = 8'h00;
                if (sel == 8'h00) begin
                    state_d = IDLE;
                end else if (state_q == IDLE || sel != cur_q) begin
                    code_d  = sel;
                    emit_d  = 1'b1;
                    cur_d   = sel;
                    state_d = HOLD;
`ifdef KEY_REPEAT_EN
                    cnt_d   = CNT_W'(REPEAT_DELAY - 1);
                end else if (cnt_q == '0) begin
                    code_d  = cur_q;
                    emit_d  = 1'b1;
                    cnt_d   = CNT_W'(REPEAT_RATE - 1);
                    state_d = REPEAT;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
`endif
                end
            end
        end

        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                state_q <= IDLE;
                cur_q   <= 8'h00;
                code_q  <= 8'h00;
                emit_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
                cnt_q   <= '0;
`endif
            end else begin
                state_q <= state_d;
                cur_q   <= cur_d;
                code_q  <= code_d;
                emit_q  <= emit_d;
`ifdef KEY_REPEAT_EN
                cnt_q   <= cnt_d;
`endif
            end
        end

        assign code_w[p] = code_q;
        assign emit_w[p] = emit_q;
    end

    assign keycode_p1 = code_w[0];
    assign keycode_p2 = code_w[1];
    assign emit_p1    = emit_w[0];
    assign emit_p2    = emit_w[1];

endmodule

// File: tb/tb_keycode_dispatch.sv
// tb/tb_keycode_dispatch.sv - directed self-checking bench for keycode_dispatch
module tb_keycode_dispatch;
    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        key_valid;
    logic [47:0] keycodes;
    logic        frame_tick;
    logic [7:0]  keycode_p1, keycode_p2;
    logic        emit_p1, emit_p2;

    int checks   = 0;
    int failures = 0;

`ifdef KEY_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    always #5 Clk = ~Clk;

    keycode_dispatch #(.NUM_SLOTS(6), .REPEAT_DELAY(8), .REPEAT_RATE(4)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .key_valid  (key_valid),
        .keycodes   (keycodes),
        .frame_tick (frame_tick),
        .keycode_p1 (keycode_p1),
        .keycode_p2 (keycode_p2),
        .emit_p1    (emit_p1),
        .emit_p2    (emit_p2)
    );

    task automatic tick(output logic [7:0] k1, output logic [7:0] k2,
                        output logic e1, output logic e2);
        @(negedge Clk);
        frame_tick = 1'b1;
        @(posedge Clk);
        #1;
        k1 = keycode_p1; k2 = keycode_p2; e1 = emit_p1; e2 = emit_p2;
        frame_tick = 1'b0;
    endtask

    task automatic send(input logic [47:0] r);
        @(negedge Clk);
        key_valid = 1'b1;
        keycodes  = r;
        @(posedge Clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    // Expected P1 emit pattern for a key held from tick 0 with DELAY=8, RATE=4
    function automatic bit held_emit(input int t);
        return (t == 0) || (REP && t >= 8 && ((t - 8) % 4) == 0);
    endfunction

    task automatic test_reset();
        logic [7:0] k1, k2;
        logic       e1, e2;
        do_reset();
        checks++;
        if ({keycode_p1, keycode_p2, emit_p1, emit_p2} !== 18'h0) begin
            failures++;
            $display("FAIL reset_state p1=%h p2=%h e1=%b e2=%b expected 00 00 0 0",
                     keycode_p1, keycode_p2, emit_p1, emit_p2);
        end
        send({40'h0, 8'h04});
        for (int t = 0; t <= 8; t++) tick(k1, k2, e1, e2);
        checks++;
        if (k1 !== (REP ? 8'h04 : 8'h00)) begin
            failures++;
            $display("FAIL reset_pre_hold p1=%h expected %h", k1, REP ? 8'h04 : 8'h00);
        end
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({keycode_p1, keycode_p2, emit_p1, emit_p2} !== 18'h0) begin
            failures++;
            $display("FAIL reset_async p1=%h p2=%h e1=%b e2=%b expected 00 00 0 0",
                     keycode_p1, keycode_p2, emit_p1, emit_p2);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        tick(k1, k2, e1, e2);
        checks++;
        if (k1 !== 8'h00 || e1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_after_tick p1=%h e1=%b expected 00 0", k1, e1);
        end
    endtask

    task automatic test_single_press();
        logic [7:0] k1, k2;
        logic       e1, e2;
        do_reset();
        send({40'h0, 8'h1A});
        for (int t = 0; t <= 20; t++) begin
            tick(k1, k2, e1, e2);
            checks++;
            if (e1 !== held_emit(t) || k1 !== (held_emit(t) ? 8'h1A : 8'h00)) begin
                failures++;
                $display("FAIL single_press_t%0d p1=%h e1=%b expected %h %b", t, k1, e1,
                         held_emit(t) ? 8'h1A : 8'h00, held_emit(t));
            end
        end
        send(48'h0);
        tick(k1, k2, e1, e2);
        checks++;
        if (k1 !== 8'h00 || e1 !== 1'b0) begin
            failures++;
            $display("FAIL single_release p1=%h e1=%b expected 00 0", k1, e1);
        end
    endtask

    task automatic test_two_players();
        logic [7:0] k1, k2;
        logic       e1, e2;
        do_reset();
        send({32'h0, 8'h04, 8'h4F});
        tick(k1, k2, e1, e2);
        checks++;
        if (k1 !== 8'h04 || k2 !== 8'h4F || e1 !== 1'b1 || e2 !== 1'b1) begin
            failures++;
            $display("FAIL two_players p1=%h p2=%h e1=%b e2=%b expected 04 4F 1 1",
                     k1, k2, e1, e2);
        end
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if (keycode_p1 !== 8'h04 || keycode_p2 !== 8'h4F || emit_p1 !== 1'b0 || emit_p2 !== 1'b0) begin
            failures++;
            $display("FAIL hold_between_ticks p1=%h p2=%h e1=%b e2=%b expected 04 4F 0 0",
                     keycode_p1, keycode_p2, emit_p1, emit_p2);
        end
        send({32'h0, 8'h1A, 8'h16});
        tick(k1, k2, e1, e2);
        checks++;
        if (k1 !== 8'h16 || e1 !== 1'b1 || k2 !== 8'h00 || e2 !== 1'b0) begin
            failures++;
            $display("FAIL slot_priority p1=%h e1=%b p2=%h e2=%b expected 16 1 00 0",
                     k1, e1, k2, e2);
        end
    endtask

    task automatic test_direction_change();
        logic [7:0] k1, k2;
        logic       e1, e2;
        bit         exp;
        do_reset();
        send({40'h0, 8'h07});
        for (int t = 0; t < 3; t++) tick(k1, k2, e1, e2);
        send({40'h0, 8'h16});
        tick(k1, k2, e1, e2);
        checks++;
        if (k1 !== 8'h16 || e1 !== 1'b1) begin
            failures++;
            $display("FAIL dir_change p1=%h e1=%b expected 16 1", k1, e1);
        end
        for (int t = 4; t <= 11; t++) begin
            tick(k1, k2, e1, e2);
            exp = REP && (t == 11);
            checks++;
            if (e1 !== exp || k1 !== (exp ? 8'h16 : 8'h00)) begin
                failures++;
                $display("FAIL dir_restart_t%0d p1=%h e1=%b expected %h %b", t, k1, e1,
                         exp ? 8'h16 : 8'h00, exp);
            end
        end
    endtask

    task automatic test_rollover();
        logic [7:0] k1, k2;
        logic       e1, e2;
        do_reset();
        send({40'h0, 8'h04});
        for (int t = 0; t <= 3; t++) tick(k1, k2, e1, e2);
        send({32'h0, 8'h16, 8'h01});
        for (int t = 4; t <= 12; t++) begin
            tick(k1, k2, e1, e2);
            checks++;
            if (e1 !== held_emit(t) || k1 !== (held_emit(t) ? 8'h04 : 8'h00)) begin
                failures++;
                $display("FAIL rollover_t%0d p1=%h e1=%b expected %h %b", t, k1, e1,
                         held_emit(t) ? 8'h04 : 8'h00, held_emit(t));
            end
        end
    endtask

    task automatic test_coincidence();
        logic [7:0] k1, k2;
        logic       e1, e2;
        do_reset();
        @(negedge Clk);
        key_valid  = 1'b1;
        keycodes   = {40'h0, 8'h52};
        frame_tick = 1'b1;
        @(posedge Clk);
        #1;
        key_valid  = 1'b0;
        frame_tick = 1'b0;
        checks++;
        if (keycode_p2 !== 8'h00 || emit_p2 !== 1'b0) begin
            failures++;
            $display("FAIL coincide_same_tick p2=%h e2=%b expected 00 0", keycode_p2, emit_p2);
        end
        tick(k1, k2, e1, e2);
        checks++;
        if (k2 !== 8'h52 || e2 !== 1'b1 || k1 !== 8'h00) begin
            failures++;
            $display("FAIL coincide_next_tick p2=%h e2=%b p1=%h expected 52 1 00", k2, e2, k1);
        end
    endtask

    initial begin
        Reset_n    = 1'b1;
        key_valid  = 1'b0;
        keycodes   = '0;
        frame_tick = 1'b0;
        test_reset();
        test_single_press();
        test_two_players();
        test_direction_change();
        test_rollover();
        test_coincidence();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
